jtag_dr_bank: RTL and testbench

- Multi-channel successor to the single-opcode JTAG data register.
- One shared shift register serves NUM_CH data registers, each selected by its own IR opcode.
- Each channel has a DR_LEN-bit payload, a capture value, and a held update output with valid/ack handshake.
- Two status bits per channel (pending, overrun) are captured and shifted out first. Sits beside the TAP controller in the tck domain.

---
 rtl/jtag_dr_bank_pkg.sv | 51 +++++
 rtl/jtag_dr_bank_chan.sv | 77 +++++++
 rtl/jtag_dr_bank.sv | 151 +++++++++++++++
 tb/tb_jtag_dr_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dr_bank_pkg.sv
// ----------------------------------------------------------------------------
// jtag_dr_bank_pkg
// Shared definitions for the multi-channel JTAG data register bank:
//   - status bit positions at the bottom of the shared shift register
//   - decoded TAP state type (after priority resolution)
//   - helpers for shift register length and opcode extraction
// No ports (package).
// ----------------------------------------------------------------------------
package jtag_dr_bank_pkg;

   // Status bits occupy the low end so they leave on tdo before the payload
   localparam int ST_PEND        = 0;
   localparam int ST_OVR         = 1;
   localparam int SR_STATUS_BITS = 2;

   // Default configuration and its shift register length
   localparam int DEF_DR_LEN = 8;
   localparam int SR_LEN     = DEF_DR_LEN + SR_STATUS_BITS;

   // Upper bounds for the generic opcode extraction helper
   localparam int MAX_IR_LEN   = 32;
   localparam int MAX_OPC_BITS = 1024;

   // One-of TAP state after priority resolution (tlr > capture > shift > update)
   typedef enum logic [2:0] {
      TAP_OTHER   = 3'd0,
      TAP_TLR     = 3'd1,
      TAP_CAPTURE = 3'd2,
      TAP_SHIFT   = 3'd3,
      TAP_UPDATE  = 3'd4
   } tap_st_e;

   // Shift register length for a given payload width
   function automatic int sr_len(input int dr_len);
      return dr_len + SR_STATUS_BITS;
   endfunction

   // Opcode of channel ch out of a zero-extended packed opcode vector
   function automatic logic [MAX_IR_LEN-1:0] opcode_at(
      input logic [MAX_OPC_BITS-1:0] ops,
      input int                      ir_len,
      input int                      ch
   );
      logic [MAX_OPC_BITS-1:0] shifted;
      logic [63:0]             mask;
      shifted = ops >> (ch * ir_len);
      mask    = (64'd1 << ir_len) - 64'd1;
      return shifted[MAX_IR_LEN-1:0] & mask[MAX_IR_LEN-1:0];
   endfunction

endpackage

// File: rtl/jtag_dr_bank_chan.sv
// ----------------------------------------------------------------------------
// jtag_dr_chan
// Per-channel holding logic: latched update value, valid/ack handshake and
// sticky overrun flag.
// Ports:
//   tck, trst      clock, async active-low reset
//   tlr            TAP Test-Logic-Reset (clears valid/overrun, keeps data)
//   update         Update-DR addressed to this channel
//   ack            consumer acknowledge
//   clr_ovr        clear-overrun request bit from the shift register
//   payload        shift register payload
//   data_out       held update value
//   valid          unconsumed update present
//   overrun        an update was dropped while valid was pending
// ----------------------------------------------------------------------------
module jtag_dr_chan
   import jtag_dr_bank_pkg::*;
#(
   parameter int DR_LEN = 8
) (
   input  logic              tck,
   input  logic              trst,
   input  logic              tlr,
   input  logic              update,
   input  logic              ack,
   input  logic              clr_ovr,
   input  logic [DR_LEN-1:0] payload,
   output logic [DR_LEN-1:0] data_out,
   output logic              valid,
   output logic              overrun
);

   logic accept;
   logic valid_nx;
   logic overrun_nx;

   // An update lands when the slot is free or is being freed this same cycle
   assign accept = update & (~valid | ack);

   // Next valid / overrun; a dropped update's set beats a same-cycle clear
   always_comb begin
      valid_nx   = valid;
      overrun_nx = overrun;
      if (update) begin
         valid_nx = 1'b1;
      end else if (ack) begin
         valid_nx = 1'b0;
      end else begin
         valid_nx = valid;
      end
      if (update && !accept) begin
         overrun_nx = 1'b1;
      end else if (update && clr_ovr) begin
         overrun_nx = 1'b0;
      end else begin
         overrun_nx = overrun;
      end
   end

   // Channel state registers; TLR drops flags but keeps the last data
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         data_out <= {DR_LEN{1'b0}};
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else if (tlr) begin
         data_out <= data_out;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         data_out <= accept ? payload : data_out;
         valid    <= valid_nx;
         overrun  <= overrun_nx;
      end
   end

endmodule

// File: rtl/jtag_dr_bank.sv
// ----------------------------------------------------------------------------
// jtag_dr_bank
// NUM_CH JTAG data registers sharing one shift register, each selected by its
// own IR opcode. Shift register layout: [0] pending, [1] overrun / clear-
// overrun, [DR_LEN+1:2] payload. Status leaves tdo first, then payload LSB
// first.
// Ports:
//   tck, trst                 TAP clock, async active-low reset
//   tdi, tdo, tdo_en          serial in, serial out, output enable
//   state_tlr/capturedr/
//   shiftdr/updatedr          TAP state indications
//   ir_reg                    current instruction
//   dr_dataIn                 per-channel capture values (packed)
//   dr_dataOut                per-channel held update values (packed)
//   dr_dataOutValid           per-channel unconsumed update
//   dr_dataOutAck             per-channel consumer acknowledge
//   dr_overrun                per-channel sticky overrun
// ----------------------------------------------------------------------------
module jtag_dr_bank
   import jtag_dr_bank_pkg::*;
#(
   parameter int                       IR_LEN     = 4,
   parameter int                       DR_LEN     = 8,
   parameter int                       NUM_CH     = 2,
   parameter logic [NUM_CH*IR_LEN-1:0] IR_OPCODES = {4'h2, 4'h1}
) (
   input  logic                     tck,
   input  logic                     trst,
   input  logic                     tdi,
   output logic                     tdo,
   output logic                     tdo_en,
   input  logic                     state_tlr,
   input  logic                     state_capturedr,
   input  logic                     state_shiftdr,
   input  logic                     state_updatedr,
   input  logic [IR_LEN-1:0]        ir_reg,
   input  logic [NUM_CH*DR_LEN-1:0] dr_dataIn,
   output logic [NUM_CH*DR_LEN-1:0] dr_dataOut,
   output logic [NUM_CH-1:0]        dr_dataOutValid,
   input  logic [NUM_CH-1:0]        dr_dataOutAck,
   output logic [NUM_CH-1:0]        dr_overrun
);

   localparam int SRL = sr_len(DR_LEN);

   logic [MAX_OPC_BITS-1:0] opc_ext;
   logic [NUM_CH-1:0]       match;
   logic [NUM_CH-1:0]       sel_onehot;
   logic                    sel_hit;
   tap_st_e                 tap_st;
   logic [DR_LEN-1:0]       cap_payload;
   logic                    cap_pend;
   logic                    cap_ovr;
   logic [SRL-1:0]          sr;
   logic [SRL-1:0]          sr_cap;

   assign opc_ext = MAX_OPC_BITS'(IR_OPCODES);

   // Raw opcode compare for every channel
   always_comb begin
      match = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         match[i] = (opcode_at(opc_ext, IR_LEN, i) == MAX_IR_LEN'(ir_reg));
      end
   end

   // Priority select: lowest matching index wins on duplicate opcodes
   always_comb begin
      logic taken;
      taken      = 1'b0;
      sel_onehot = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         sel_onehot[i] = match[i] & ~taken;
         taken         = taken | match[i];
      end
   end

   assign sel_hit = |match;
   assign tdo_en  = sel_hit;

   // Resolve TAP state inputs into one state, tlr > capture > shift > update
   always_comb begin
      tap_st = TAP_OTHER;
      if (state_tlr) begin
         tap_st = TAP_TLR;
      end else if (state_capturedr) begin
         tap_st = TAP_CAPTURE;
      end else if (state_shiftdr) begin
         tap_st = TAP_SHIFT;
      end else if (state_updatedr) begin
         tap_st = TAP_UPDATE;
      end else begin
         tap_st = TAP_OTHER;
      end
   end

   // AND-OR mux of the selected channel's capture value and status
   always_comb begin
      cap_payload = {DR_LEN{1'b0}};
      cap_pend    = 1'b0;
      cap_ovr     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cap_payload = cap_payload |
                       (dr_dataIn[i*DR_LEN +: DR_LEN] & {DR_LEN{sel_onehot[i]}});
         cap_pend    = cap_pend | (dr_dataOutValid[i] & sel_onehot[i]);
         cap_ovr     = cap_ovr  | (dr_overrun[i]      & sel_onehot[i]);
      end
   end

   // Capture word layout: payload above the two status bits
   always_comb begin
      sr_cap             = {SRL{1'b0}};
      sr_cap[SRL-1:2]    = cap_payload;
      sr_cap[ST_OVR]     = cap_ovr;
      sr_cap[ST_PEND]    = cap_pend;
   end

   // Shared shift register; capture/shift only act for a selected channel
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         sr <= {SRL{1'b0}};
      end else begin
         case (tap_st)
            TAP_TLR:     sr <= {SRL{1'b0}};
            TAP_CAPTURE: sr <= sel_hit ? sr_cap : sr;
            TAP_SHIFT:   sr <= sel_hit ? {tdi, sr[SRL-1:1]} : sr;
            default:     sr <= sr;
         endcase
      end
   end

   assign tdo = sel_hit & sr[ST_PEND];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      jtag_dr_chan #(
         .DR_LEN (DR_LEN)
      ) u_chan (
         .tck      (tck),
         .trst     (trst),
         .tlr      (state_tlr),
         .update   ((tap_st == TAP_UPDATE) & sel_onehot[g]),
         .ack      (dr_dataOutAck[g]),
         .clr_ovr  (sr[ST_OVR]),
         .payload  (sr[SRL-1:2]),
         .data_out (dr_dataOut[g*DR_LEN +: DR_LEN]),
         .valid    (dr_dataOutValid[g]),
         .overrun  (dr_overrun[g])
      );
   end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// ----------------------------------------------------------------------------
// tb_jtag_dr_bank
// Self-checking bench for jtag_dr_bank (defaults: IR_LEN=4, DR_LEN=8,
// NUM_CH=2, ch0 opcode 4'h1, ch1 opcode 4'h2). Expected tdo bits are queued
// before each scan and popped as each bit appears.
// ----------------------------------------------------------------------------
module tb_jtag_dr_bank;

   logic        tck;
   logic        trst;
   logic        tdi;
   logic        tdo;
   logic        tdo_en;
   logic        state_tlr;
   logic        state_capturedr;
   logic        state_shiftdr;
   logic        state_updatedr;
   logic [3:0]  ir_reg;
   logic [15:0] dr_dataIn;
   logic [15:0] dr_dataOut;
   logic [1:0]  dr_dataOutValid;
   logic [1:0]  dr_dataOutAck;
   logic [1:0]  dr_overrun;

   int   checks;
   int   failures;
   logic exp_q[$];

   jtag_dr_bank dut (
      .tck             (tck),
      .trst            (trst),
      .tdi             (tdi),
      .tdo             (tdo),
      .tdo_en          (tdo_en),
      .state_tlr       (state_tlr),
      .state_capturedr (state_capturedr),
      .state_shiftdr   (state_shiftdr),
      .state_updatedr  (state_updatedr),
      .ir_reg          (ir_reg),
      .dr_dataIn       (dr_dataIn),
      .dr_dataOut      (dr_dataOut),
      .dr_dataOutValid (dr_dataOutValid),
      .dr_dataOutAck   (dr_dataOutAck),
      .dr_overrun      (dr_overrun)
   );

   // Free-running TAP clock
   initial tck = 1'b0;
   always #5 tck = ~tck;

   // Time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // Queue the bits a capture should shift out: pending, overrun, payload LSB first
   task automatic push_cap(input logic pend, input logic ovr, input logic [7:0] payload);
      exp_q.push_back(pend);
      exp_q.push_back(ovr);
      for (int k = 0; k < 8; k++) exp_q.push_back(payload[k]);
   endtask

   task automatic pop_tdo();
      if (exp_q.size() == 0) begin
         check_val("tdo_q_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
         check_val("tdo", {31'd0, tdo}, {31'd0, exp_q.pop_front()});
      end
   endtask

   // Capture, shift 10 bits (sr_in[0] first), optional update with given acks
   task automatic scan(input logic [3:0] ir, input logic [9:0] sr_in,
                       input bit do_upd, input logic [1:0] upd_ack);
      ir_reg          = ir;
      state_capturedr = 1'b1;
      tick();
      state_capturedr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         pop_tdo();
         tdi           = sr_in[k];
         state_shiftdr = 1'b1;
         tick();
      end
      state_shiftdr = 1'b0;
      tdi           = 1'b0;
      if (do_upd) begin
         state_updatedr = 1'b1;
         dr_dataOutAck  = upd_ack;
         tick();
         state_updatedr = 1'b0;
         dr_dataOutAck  = 2'b00;
      end
   endtask

   initial begin
      logic [9:0] a5_seq;
      checks          = 0;
      failures        = 0;
      trst            = 1'b0;
      tdi             = 1'b0;
      state_tlr       = 1'b0;
      state_capturedr = 1'b0;
      state_shiftdr   = 1'b0;
      state_updatedr  = 1'b0;
      ir_reg          = 4'hF;
      dr_dataIn       = {8'h5A, 8'hA5};
      dr_dataOutAck   = 2'b00;

      #3;
      check_val("rst_data", 32'(dr_dataOut), 32'h0);
      check_val("rst_valid", 32'(dr_dataOutValid), 32'h0);
      check_val("rst_ovr", 32'(dr_overrun), 32'h0);
      check_val("rst_tdo", {31'd0, tdo}, 32'd0);
      check_val("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
      @(negedge tck);
      trst = 1'b1;
      tick();

      // Load ch0 so the reset has something to clear
      push_cap(1'b0, 1'b0, 8'hA5);
      scan(4'h1, {8'h77, 2'b00}, 1'b1, 2'b00);
      check_val("pre_rst_data0", 32'(dr_dataOut[7:0]), 32'h77);
      check_val("pre_rst_valid", 32'(dr_dataOutValid), 32'h1);

      // Reset mid-shift: capture (pending=1 now), shift a bit, then async reset
      state_capturedr = 1'b1;
      tick();
      state_capturedr = 1'b0;
      check_val("cap_pend_tdo", {31'd0, tdo}, 32'd1);
      state_shiftdr = 1'b1;
      tdi           = 1'b1;
      tick();
      #2;
      trst = 1'b0;
      #1;
      check_val("mid_rst_tdo", {31'd0, tdo}, 32'd0);
      check_val("mid_rst_data", 32'(dr_dataOut), 32'h0);
      check_val("mid_rst_valid", 32'(dr_dataOutValid), 32'h0);
      check_val("mid_rst_ovr", 32'(dr_overrun), 32'h0);
      state_shiftdr = 1'b0;
      tdi           = 1'b0;
      @(negedge tck);
      trst = 1'b1;
      tick();

      // ch0 capture of 8'hA5: tdo 0,0,1,0,1,0,0,1,0,1
      a5_seq = 10'b1010010100;
      for (int k = 0; k < 10; k++) exp_q.push_back(a5_seq[k]);
      scan(4'h1, 10'h000, 1'b0, 2'b00);
      check_val("tdo_en_ch0", {31'd0, tdo_en}, 32'd1);

      // ch1 update 8'h3C, then ack
      push_cap(1'b0, 1'b0, 8'h5A);
      scan(4'h2, {8'h3C, 2'b00}, 1'b1, 2'b00);
      check_val("ch1_data", 32'(dr_dataOut[15:8]), 32'h3C);
      check_val("ch1_ch0_untouched", 32'(dr_dataOut[7:0]), 32'h00);
      check_val("ch1_valid", 32'(dr_dataOutValid), 32'h2);
      dr_dataOutAck = 2'b10;
      tick();
      dr_dataOutAck = 2'b00;
      check_val("ch1_ack_valid", 32'(dr_dataOutValid), 32'h0);

      // Two unacked updates to ch0 -> overrun, first data held
      push_cap(1'b0, 1'b0, 8'hA5);
      scan(4'h1, {8'h11, 2'b00}, 1'b1, 2'b00);
      push_cap(1'b1, 1'b0, 8'hA5);
      scan(4'h1, {8'h22, 2'b00}, 1'b1, 2'b00);
      check_val("ovr_data0", 32'(dr_dataOut[7:0]), 32'h11);
      check_val("ovr_flag", 32'(dr_overrun), 32'h1);
      check_val("ovr_valid", 32'(dr_dataOutValid), 32'h1);
      // Status 1,1 first; clear-overrun with ack during update
      push_cap(1'b1, 1'b1, 8'hA5);
      scan(4'h1, {8'h22, 1'b1, 1'b0}, 1'b1, 2'b01);
      check_val("clr_ovr_flag", 32'(dr_overrun), 32'h0);
      check_val("clr_ovr_data0", 32'(dr_dataOut[7:0]), 32'h22);
      check_val("clr_ovr_valid", 32'(dr_dataOutValid), 32'h1);

      // ch1 update with same-cycle ack while valid
      push_cap(1'b0, 1'b0, 8'h5A);
      scan(4'h2, {8'h44, 2'b00}, 1'b1, 2'b00);
      check_val("ch1_44", 32'(dr_dataOut[15:8]), 32'h44);
      push_cap(1'b1, 1'b0, 8'h5A);
      scan(4'h2, {8'h55, 2'b00}, 1'b1, 2'b10);
      check_val("upd_ack_data1", 32'(dr_dataOut[15:8]), 32'h55);
      check_val("upd_ack_valid", 32'(dr_dataOutValid), 32'h3);
      check_val("upd_ack_ovr", 32'(dr_overrun), 32'h0);
      // Unacked update to ch1 -> overrun[1]
      push_cap(1'b1, 1'b0, 8'h5A);
      scan(4'h2, {8'h66, 2'b00}, 1'b1, 2'b00);
      check_val("ovr1_data1", 32'(dr_dataOut[15:8]), 32'h55);
      check_val("ovr1_flag", 32'(dr_overrun), 32'h2);

      // Unmapped opcode: everything ignored, tdo stays 0
      for (int k = 0; k < 10; k++) exp_q.push_back(1'b0);
      scan(4'hF, 10'h3FF, 1'b1, 2'b00);
      check_val("unmap_tdo_en", {31'd0, tdo_en}, 32'd0);
      check_val("unmap_data", 32'(dr_dataOut), 32'h5522);
      check_val("unmap_valid", 32'(dr_dataOutValid), 32'h3);
      check_val("unmap_ovr", 32'(dr_overrun), 32'h2);

      // Test-Logic-Reset: flags cleared, data retained
      state_tlr = 1'b1;
      tick();
      state_tlr = 1'b0;
      check_val("tlr_valid", 32'(dr_dataOutValid), 32'h0);
      check_val("tlr_ovr", 32'(dr_overrun), 32'h0);
      check_val("tlr_data", 32'(dr_dataOut), 32'h5522);
      ir_reg = 4'h1;
      #1;
      check_val("tlr_sr_tdo", {31'd0, tdo}, 32'd0);

      check_val("tdo_q_left", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
